// File: rtl/sum_display_driver_pkg.sv
// Shared constants for the adder-result display driver: FSM encoding,
// seven-segment patterns (active-low gfedcba), anode patterns and BCD types.
package sum_display_driver_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;

  // One shift per binary input bit.
  localparam logic [2:0] CONV_ITERS = 3'd5;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Results are 0..31, so tens never exceeds 3.
  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

endpackage

// File: rtl/sum_display_driver_bcd_to_seven_seg.sv
// Combinational BCD digit to active-low seven-segment pattern; zero latency.
// Non-decimal codes produce a blank pattern.
module bcd_to_seven_seg
  import sum_display_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display_driver.sv
// Captures a 5-bit adder result, converts it to BCD by double-dabble (6 cycles
// load to display) and multiplexes two digits; loads while busy are dropped.
module sum_display_driver
  import sum_display_driver_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] Data,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  logic [1:0]              state_q,   state_d;
  logic [4:0]              bin_q,     bin_d;
  bcd_pair_t               scr_q,     scr_d;
  logic [2:0]              iter_q,    iter_d;
  bcd_pair_t               disp_q,    disp_d;
  logic                    busy_q,    busy_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

  logic [3:0] ones_adj;
  logic       sel_tens;
  logic       blank_tens;
  logic [3:0] digit;
  logic [6:0] seg_raw;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    iter_d   = iter_q;
    disp_d   = disp_q;
    busy_d   = busy_q;
    ones_adj = scr_q.ones;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = Data;
          scr_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Tens stays <= 3 for a 5-bit input, so only the ones digit needs add-3.
        ones_adj = (scr_q.ones >= 4'd5) ? (scr_q.ones + 4'd3) : scr_q.ones;
        {scr_d.tens, scr_d.ones, bin_d} = {scr_q.tens[0], ones_adj, bin_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == CONV_ITERS - 3'd1) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        disp_d  = scr_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + REFRESH_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scr_q     <= '0;
      iter_q    <= '0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scr_q     <= scr_d;
      iter_q    <= iter_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      refresh_q <= refresh_d;
    end
  end

  always_comb begin
    sel_tens   = refresh_q[REFRESH_BITS-1];
    blank_tens = sel_tens && (BLANK_LZ != 0) && (disp_q.tens == 2'd0);
    digit      = sel_tens ? {2'b00, disp_q.tens} : disp_q.ones;
  end

  bcd_to_seven_seg u_bcd_to_seven_seg (
    .bcd (digit),
    .seg (seg_raw)
  );

  always_comb begin
    seg  = blank_tens ? SEG_BLANK : seg_raw;
    an   = blank_tens ? AN_OFF : (sel_tens ? AN_TENS : AN_ONES);
    busy = busy_q;
    dp   = 1'b1;
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: two instances (leading-zero blanking on/off)
// share stimulus and are checked against an arithmetic decimal-display model.
module tb_sum_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [4:0] Data;

  logic       busy_b, busy_n;
  logic [6:0] seg_b,  seg_n;
  logic [3:0] an_b,   an_n;
  logic       dp_b,   dp_n;

  int checks = 0;
  int errors = 0;

  logic [6:0] segtab [0:9];
  logic [3:0] m_cnt;

  typedef struct {
    logic [4:0] data;
    int         tens;
    int         ones;
  } vec_t;
  vec_t vecs [0:6];

  sum_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .Data  (Data),
    .busy  (busy_b),
    .seg   (seg_b),
    .an    (an_b),
    .dp    (dp_b)
  );

  sum_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(0)) dut_n (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .Data  (Data),
    .busy  (busy_n),
    .seg   (seg_n),
    .an    (an_n),
    .dp    (dp_n)
  );

  always #5 clk = ~clk;

  // Reference refresh position: cycles elapsed since reset, modulo 16.
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= 4'd0;
    else       m_cnt <= m_cnt + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_display(input int t, input int o, input string name);
    logic [6:0] es_b, es_n;
    logic [3:0] ea_b, ea_n;
    for (int c = 0; c < 16; c++) begin
      if (!m_cnt[3]) begin
        ea_b = 4'b1110; es_b = segtab[o];
        ea_n = 4'b1110; es_n = segtab[o];
      end else begin
        ea_n = 4'b1101; es_n = segtab[t];
        if (t == 0) begin
          ea_b = 4'b1111; es_b = 7'b1111111;
        end else begin
          ea_b = ea_n; es_b = es_n;
        end
      end
      chk({name, " an blz1"},  an_b,  ea_b);
      chk({name, " seg blz1"}, seg_b, es_b);
      chk({name, " an blz0"},  an_n,  ea_n);
      chk({name, " seg blz0"}, seg_n, es_n);
      chk({name, " dp"}, {dp_b, dp_n}, 2'b11);
      tick;
    end
  endtask

  task automatic do_load(input logic [4:0] d);
    load = 1'b1;
    Data = d;
    tick;
    load = 1'b0;
    Data = 5'($urandom_range(0, 31));
  endtask

  task automatic load_and_check(input logic [4:0] d, input int t, input int o, input string name);
    do_load(d);
    for (int i = 0; i < 6; i++) begin
      chk({name, " busy during"}, {busy_b, busy_n}, 2'b11);
      tick;
    end
    chk({name, " busy after"}, {busy_b, busy_n}, 2'b00);
    check_display(t, o, name);
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;

    vecs[0] = '{5'd31, 3, 1};
    vecs[1] = '{5'd7,  0, 7};
    vecs[2] = '{5'd0,  0, 0};
    vecs[3] = '{5'd10, 1, 0};
    vecs[4] = '{5'd19, 1, 9};
    vecs[5] = '{5'd25, 2, 5};
    vecs[6] = '{5'd9,  0, 9};

    reset = 1'b1;
    load  = 1'b0;
    Data  = 5'd0;
    #3;
    chk("reset busy", {busy_b, busy_n}, 2'b00);
    chk("reset an",   an_b,  4'b1110);
    chk("reset seg",  seg_b, 7'b1000000);
    chk("reset dp",   dp_b,  1'b1);
    #9 reset = 1'b0;
    tick;
    check_display(0, 0, "post reset");

    for (int v = 0; v < 7; v++) begin
      load_and_check(vecs[v].data, vecs[v].tens, vecs[v].ones,
                     $sformatf("vec %0d", vecs[v].data));
    end

    // Loads at k+2 and on the UPDATE edge (k+6) must both be dropped.
    do_load(5'd19);
    tick;
    load = 1'b1; Data = 5'd5;
    tick;
    load = 1'b0;
    tick; tick; tick;
    load = 1'b1; Data = 5'd5;
    tick;
    load = 1'b0;
    chk("ignored loads busy k+6", {busy_b, busy_n}, 2'b00);
    tick;
    chk("ignored loads no restart", {busy_b, busy_n}, 2'b00);
    check_display(1, 9, "ignored loads");

    // Asynchronous reset in the middle of a conversion.
    do_load(5'd25);
    tick; tick;
    #2 reset = 1'b1;
    #1;
    chk("midconv reset busy", {busy_b, busy_n}, 2'b00);
    chk("midconv reset an",   an_b,  4'b1110);
    chk("midconv reset seg",  seg_b, 7'b1000000);
    chk("midconv reset dp",   dp_b,  1'b1);
    #3 reset = 1'b0;
    tick;
    chk("after reset idle", {busy_b, busy_n}, 2'b00);
    check_display(0, 0, "after midconv reset");
    load_and_check(5'd10, 1, 0, "reload 10");

    for (int r = 0; r < 24; r++) begin
      logic [4:0] d;
      int gap;
      d   = 5'($urandom_range(0, 31));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick;
      load_and_check(d, int'(d) / 10, int'(d) % 10, $sformatf("rand %0d", d));
    end

    for (int s = 0; s < 32; s++) begin
      load_and_check(5'(s), s / 10, s % 10, $sformatf("sweep %0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
